// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 10;
    localparam int   DEFAULT_DATA_BITS    = 8;
    localparam logic LINE_IDLE            = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        LOAD      = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer
// Description : Per-bit cycle counter and data-bit counter for the UART
//               receiver; strobes at the sample point of every bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_POINT = 5,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    input  logic half_period,
    input  logic count_bits,
    output logic sample_strobe,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] c_full_last = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(SAMPLE_POINT - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);

    logic [CW-1:0] r_cycle_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [CW-1:0] w_terminal;

    // The counter wraps on every strobe, so each phase starts from zero
    // without the controller having to clear it between phases.
    always_comb begin
        w_terminal    = half_period ? c_half_last : c_full_last;
        sample_strobe = enable && (r_cycle_cnt == w_terminal);
        bit_done      = sample_strobe && count_bits && (r_bit_cnt == c_bit_last);
    end

    always_ff @(posedge clk) begin
        if (n_rst || clear) begin
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
        end else if (enable) begin
            r_cycle_cnt <= sample_strobe ? '0 : r_cycle_cnt + 1'b1;
            if (sample_strobe && count_bits) begin
                r_bit_cnt <= bit_done ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller: start detection, mid-bit timing,
//               shift strobes, stop check and ready/read holding buffer.
//               Define UART_RX_PARITY_EN to add an even-parity bit check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int SAMPLE_POINT = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS-1:0] sr_data,
    input  logic                 data_read,
    output logic                 shift_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 receiving,
    output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                 overrun_error,
    output logic                 parity_error
`else
    output logic                 overrun_error
`endif
);

    state_t r_state;
    state_t w_next_state;

    logic r_sync1;
    logic r_sync2;
    logic r_line_prev;
    logic w_line_s;
    logic w_start_edge;

    logic w_timer_clear;
    logic w_timer_en;
    logic w_half_period;
    logic w_count_bits;
    logic w_strobe;
    logic w_bit_done;

    logic w_start_ok;
    logic w_stop_bad;
    logic w_do_load;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_framing_error;
    logic                 r_overrun_error;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_sync1     <= LINE_IDLE;
            r_sync2     <= LINE_IDLE;
            r_line_prev <= LINE_IDLE;
        end else begin
            r_sync1     <= serial_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    assign w_line_s     = r_sync2;
    assign w_start_edge = r_line_prev && !w_line_s;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT),
        .DATA_BITS    (DATA_BITS)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_timer_clear),
        .enable        (w_timer_en),
        .half_period   (w_half_period),
        .count_bits    (w_count_bits),
        .sample_strobe (w_strobe),
        .bit_done      (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_edge) w_next_state = START_CHK;
            end
            START_CHK: begin
                if (w_strobe) w_next_state = w_line_s ? IDLE : DATA;
            end
            DATA: begin
`ifdef UART_RX_PARITY_EN
                if (w_bit_done) w_next_state = PARITY;
`else
                if (w_bit_done) w_next_state = STOP;
`endif
            end
            PARITY: begin
                if (w_strobe) w_next_state = STOP;
            end
            STOP: begin
                if (w_strobe) w_next_state = w_line_s ? LOAD : WAIT_IDLE;
            end
            LOAD: begin
                w_next_state = IDLE;
            end
            WAIT_IDLE: begin
                if (w_line_s == LINE_IDLE) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The shift strobe is gated by reset so an aborted frame never shifts.
    always_comb begin
        w_timer_en    = (r_state == START_CHK) || (r_state == DATA) ||
                        (r_state == PARITY)    || (r_state == STOP);
        w_timer_clear = !w_timer_en;
        w_half_period = (r_state == START_CHK);
        w_count_bits  = (r_state == DATA);
        shift_enable  = (r_state == DATA) && w_strobe && !n_rst;
        receiving     = (r_state != IDLE);
        w_start_ok    = (r_state == START_CHK) && w_strobe && !w_line_s;
        w_stop_bad    = (r_state == STOP) && w_strobe && !w_line_s;
        w_do_load     = (r_state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_rx_data       <= '1;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            if (w_start_ok) r_framing_error <= 1'b0;
            if (w_stop_bad) r_framing_error <= 1'b1;
            // A read coinciding with a load is consumed by the load itself.
            if (w_do_load) begin
                r_rx_data    <= sr_data;
                r_data_ready <= 1'b1;
                if (data_read) begin
                    r_overrun_error <= 1'b0;
                end else if (r_data_ready) begin
                    r_overrun_error <= 1'b1;
                end
            end else if (data_read) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_error;
    logic w_parity_bad;

    // Even parity: data bits plus the parity bit must hold an even count of ones.
    assign w_parity_bad = ^{sr_data, w_line_s};

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_parity_error <= 1'b0;
        end else if (w_start_ok) begin
            r_parity_error <= 1'b0;
        end else if ((r_state == PARITY) && w_strobe && w_parity_bad) begin
            r_parity_error <= 1'b1;
        end
    end

    assign parity_error = r_parity_error;
`endif

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Scoreboard bench for uart_rx_ctrl with a companion shift
//               register; directed scenarios followed by random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int C  = 10;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic          tb_clk    = 1'b0;
    logic          n_rst     = 1'b1;
    logic          serial_in = 1'b1;
    logic          data_read = 1'b0;
    logic [DB-1:0] sr_data   = '1;
    wire           shift_enable;
    wire  [DB-1:0] rx_data;
    wire           data_ready;
    wire           receiving;
    wire           framing_error;
    wire           overrun_error;
`ifdef UART_RX_PARITY_EN
    wire           parity_error;
`endif

    always #5 tb_clk = ~tb_clk;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB)
    ) dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .sr_data       (sr_data),
        .data_read     (data_read),
        .shift_enable  (shift_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .receiving     (receiving),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
`ifdef UART_RX_PARITY_EN
        , .parity_error (parity_error)
`endif
    );

    // Downstream LSB-first shift register: the first bit ends up in bit 0.
    always @(posedge tb_clk) begin
        if (shift_enable) sr_data <= {serial_in, sr_data[DB-1:1]};
    end

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DB-1:0] data;
        logic          overrun;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    bit            m_unread = 1'b0;
    int            shift_count = 0;
    int            shift_edges[$];
    int            last_load_edge = -1;
    logic          prev_ready = 1'b0;
    logic [DB-1:0] prev_rx = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: a load is a rising data_ready or a new value under data_ready.
    always @(negedge tb_clk) begin
        if (shift_enable === 1'b1) begin
            shift_count++;
            shift_edges.push_back(cyc + 1);
        end
        if (data_ready === 1'b1 && (!prev_ready || rx_data != prev_rx)) begin
            last_load_edge = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: rx_data=%0h, expected no load", rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("load_rx_data", 32'(rx_data), 32'(mon_e.data));
                chk("load_overrun", 32'(overrun_error), 32'(mon_e.overrun));
                chk("load_framing", 32'(framing_error), 32'd0);
`ifdef UART_RX_PARITY_EN
                chk("load_parity", 32'(parity_error), 32'd0);
`endif
            end
        end
        prev_ready = data_ready;
        prev_rx    = rx_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    // Caller is always 1 time unit past a rising edge, so frames can abut.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic expect_load, output int t0);
        if (expect_load) begin
            exp_q.push_back('{data: d, overrun: m_unread});
            m_unread = 1'b1;
        end
        serial_in = 1'b0;
        t0 = cyc + 1;
        tick(C);
        for (int i = 0; i < DB; i++) begin
            serial_in = d[i];
            tick(C);
        end
        if (PBITS != 0) begin
            serial_in = ^d;
            tick(C);
        end
        serial_in = stop_bit;
        tick(C);
        serial_in = 1'b1;
    endtask

    task automatic do_read();
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
        m_unread  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'hFF);
        chk({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        chk({tag, "_receiving"}, 32'(receiving), 32'd0);
        chk({tag, "_framing"}, 32'(framing_error), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun_error), 32'd0);
        chk({tag, "_shift_en"}, 32'(shift_enable), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t0;
        int            s0;
        int            rec;
        logic [DB-1:0] d;
        logic [DB-1:0] last_d;

        tick(3);
        chk_reset_outputs("reset_init");
        n_rst = 1'b0;
        tick(5);

        // Reset held two cycles while idle.
        s0    = shift_count;
        n_rst = 1'b1;
        tick(2);
        chk_reset_outputs("reset_idle");
        n_rst = 1'b0;
        tick(3);
        chk("reset_idle_no_shift", 32'(shift_count - s0), 32'd0);

        // Frame 0xA5 with exact strobe and load timing.
        shift_edges.delete();
        send_frame(8'hA5, 1'b1, 1'b1, t0);
        chk("a5_shift_count", 32'(shift_edges.size()), 32'd8);
        for (int k = 0; k < DB; k++) begin
            if (k < shift_edges.size())
                chk($sformatf("a5_shift_edge_%0d", k), 32'(shift_edges[k] - t0), 32'(17 + C * k));
        end
        chk("a5_load_edge", 32'(last_load_edge - t0), 32'(98 + PBITS * C));
        chk("a5_rx_data", 32'(rx_data), 32'hA5);
        do_read();
        chk("a5_read_clears_ready", 32'(data_ready), 32'd0);

        // Three-cycle low glitch on an idle line.
        tick(4);
        s0        = shift_count;
        rec       = 0;
        serial_in = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge tb_clk);
            if (receiving) rec++;
            @(posedge tb_clk);
            #1;
            if (i == 2) serial_in = 1'b1;
        end
        chk("glitch_recv_le6", 32'(rec <= 6 && rec >= 1), 32'd1);
        chk("glitch_no_shift", 32'(shift_count - s0), 32'd0);
        chk("glitch_idle", 32'(receiving), 32'd0);
        chk("glitch_no_ready", 32'(data_ready), 32'd0);

        // Bad stop bit, then a good frame clears the framing error.
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        tick(5);
        chk("frame_err_set", 32'(framing_error), 32'd1);
        chk("frame_err_no_ready", 32'(data_ready), 32'd0);
        send_frame(8'h55, 1'b1, 1'b1, t0);
        chk("frame_err_cleared", 32'(framing_error), 32'd0);
        chk("frame_55_data", 32'(rx_data), 32'h55);
        do_read();

        // Back-to-back frames without a read produce an overrun.
        tick(3);
        send_frame(8'h01, 1'b1, 1'b1, t0);
        send_frame(8'h02, 1'b1, 1'b1, t0);
        chk("ovr_rx_data", 32'(rx_data), 32'h02);
        chk("ovr_flag", 32'(overrun_error), 32'd1);
        do_read();
        chk("ovr_read_ready", 32'(data_ready), 32'd0);
        chk("ovr_read_flag", 32'(overrun_error), 32'd0);

        // Reset pulsed during data bit 3 aborts the frame.
        tick(4);
        d         = 8'hC3;
        s0        = shift_count;
        serial_in = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            serial_in = d[i];
            tick(C);
        end
        serial_in = d[3];
        tick(5);
        chk("abort_shifts_before_reset", 32'(shift_count - s0), 32'd3);
        n_rst = 1'b1;
        tick(1);
        n_rst     = 1'b0;
        serial_in = 1'b1;
        m_unread  = 1'b0;
        chk_reset_outputs("abort");
        s0 = shift_count;
        tick(120);
        chk("abort_no_shift", 32'(shift_count - s0), 32'd0);
        chk("abort_no_load", 32'(data_ready), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b1, t0);
        chk("abort_next_c3", 32'(rx_data), 32'hC3);
        do_read();

        // Random frames, gaps and read decisions.
        last_d = 8'hC3;
        for (int n = 0; n < 16; n++) begin
            tick($urandom_range(0, 25));
            d = DB'($urandom);
            if (m_unread && d == last_d) d = d ^ 8'h5A;
            send_frame(d, 1'b1, 1'b1, t0);
            last_d = d;
            if ($urandom_range(0, 3) != 0) do_read();
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the serial link.
- Sits directly upstream of the LSB-first serial-to-parallel shift register and drives that register's shift_enable. Finds the start bit, times every bit to mid-period, and strobes each data bit into the register.
- Checks the stop bit, then captures the register's parallel output into a holding buffer behind a ready/read handshake.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit (must be >= 4)
- DATA_BITS, 8, data bits per frame; equals the shift register width
- SAMPLE_POINT, CLKS_PER_BIT/2, cycles from detected start edge to the start-bit sample

Ports:
- clk  input  1  system clock; rising edge only
- n_rst  input  1  reset; synchronous, active-high (name kept per codebase convention)
- serial_in  input  1  raw asynchronous line; idle level 1
- sr_data  input  DATA_BITS  parallel_out of the downstream shift register
- data_read  input  1  consumer has taken rx_data (one-cycle pulse)
- shift_enable  output  1  one-cycle strobe to the shift register; serial_in is valid at that edge
- rx_data  output  DATA_BITS  captured frame
- data_ready  output  1  rx_data holds an unread frame
- receiving  output  1  high in any state except IDLE
- framing_error  output  1  stop bit sampled 0
- overrun_error  output  1  new frame loaded while data_ready was still 1

Behaviour:
- Reset (n_rst=1 at a clock edge):
  - all outputs to 0, except rx_data, which resets to all ones;
  - synchroniser flops to 1; FSM to IDLE; counters to 0.
- Reset mid-frame aborts the frame. No shift_enable, no load.
- Synchroniser: two flops on serial_in, giving line_s. Start edge = line_s 1->0 (previous-value flop).
- Latency: t0 is the edge where the first sync flop captures 0, so line_s=0 from t0+2. Bit k (k=0..DATA_BITS-1) shift_enable pulses at cycle t0+2+SAMPLE_POINT+(k+1)*CLKS_PER_BIT.
- FSM states and transitions:
  - IDLE: on start edge, go to START_CHK and clear the cycle counter.
  - START_CHK: at counter==SAMPLE_POINT-1, sample line_s.
    - 0: go to DATA and clear framing_error.
    - 1: treat as a glitch and return to IDLE with no outputs changed.
  - DATA: the counter runs 0..CLKS_PER_BIT-1 and wraps.
    - At CLKS_PER_BIT-1, pulse shift_enable for exactly one cycle and increment the bit counter.
    - After the DATA_BITS-th pulse, go to STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample line_s.
    - 1: go to LOAD.
    - 0: set framing_error and go to WAIT_IDLE.
  - LOAD (one cycle): rx_data <= sr_data; data_ready <= 1; if data_ready was already 1 and data_read is 0, set overrun_error. Then go to IDLE.
  - WAIT_IDLE: stay until line_s==1, then go to IDLE. No start detection in this state.
- Handshake:
  - data_read clears data_ready on the next edge.
  - data_read in the same cycle as LOAD: the load wins, data_ready stays 1, no overrun.
  - overrun_error clears on data_read.
- A back-to-back frame (start edge right after the stop sample) must be caught with no lost cycle; IDLE lasts 1 cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - a PARITY state sits between DATA and STOP and samples at CLKS_PER_BIT-1;
  - even parity is computed over the shifted-in bits;
  - output parity_error (1 bit) is set on mismatch and cleared on the next valid start;
  - the frame still loads, and data_ready still asserts.
- When undefined: no PARITY state and no parity_error port.

Decomposition:
- Package uart_rx_pkg:
  - state_t enum (IDLE, START_CHK, DATA, PARITY, STOP, LOAD, WAIT_IDLE);
  - default CLKS_PER_BIT and DATA_BITS constants;
  - LINE_IDLE = 1'b1.
- Sub-module rx_bit_timer: cycle counter plus bit counter, with inputs clear/enable and outputs sample_strobe/bit_done. Instantiated once.

Test Plan:
- Reset held 2 cycles mid-idle -> all outputs 0, rx_data=8'hFF, shift_enable never pulses.
- Frame 0xA5 sent LSB-first (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with a companion SR instance -> 8 shift_enable pulses, first at t0+17, spaced exactly 10 cycles; data_ready at t0+98; rx_data=8'hA5.
- 3-cycle low glitch on an idle line -> return to IDLE, zero shift_enable pulses, receiving high for at most 6 cycles.
- Frame 0x3C with stop bit 0 -> framing_error=1, data_ready stays 0; after the line returns high, a valid 0x55 frame clears framing_error and loads 8'h55.
- Two back-to-back frames 0x01 then 0x02 with no data_read -> second load sets overrun_error, rx_data=8'h02; data_read clears data_ready and overrun_error next cycle.
- n_rst pulsed during bit 3 of a frame -> outputs return to reset values, no load; the next full frame 0xC3 is received correctly.
